// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the three-way memory port arbiter: FSM states, requester ids and
// the alignment check.
package mem_arb_pkg;

  localparam int unsigned RSP_ID_W = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } arb_state_t;

  typedef enum logic [RSP_ID_W-1:0] {
    REQ_FETCH = 2'd0,
    REQ_LOAD  = 2'd1,
    REQ_STORE = 2'd2
  } req_id_t;

  function automatic logic is_misaligned(input logic [1:0] lsb);
    return lsb != 2'b00;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester, memory and response signals of the arbiter. The slave modport is the arbiter;
// the master modport is everything around it (requesters plus the RAM).
interface mem_port_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) ();

  logic                fetch_valid;
  logic                fetch_ready;
  logic [ADDR_W-1:0]   fetch_addr;
  logic                load_valid;
  logic                load_ready;
  logic [ADDR_W-1:0]   load_addr;
  logic                store_valid;
  logic                store_ready;
  logic [ADDR_W-1:0]   store_addr;
  logic [DATA_W-1:0]   store_data;
  logic                mem_en;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_wdata;
  logic [DATA_W-1:0]   mem_rdata;
  logic                rsp_valid;
  logic [RSP_ID_W-1:0] rsp_id;
  logic [DATA_W-1:0]   rsp_data;
  logic                rsp_err;

  modport master (
    output fetch_valid, fetch_addr, load_valid, load_addr, store_valid, store_addr, store_data,
    output mem_rdata,
    input  fetch_ready, load_ready, store_ready, mem_en, mem_we, mem_addr, mem_wdata,
    input  rsp_valid, rsp_id, rsp_data, rsp_err
  );

  modport slave (
    input  fetch_valid, fetch_addr, load_valid, load_addr, store_valid, store_addr, store_data,
    input  mem_rdata,
    output fetch_ready, load_ready, store_ready, mem_en, mem_we, mem_addr, mem_wdata,
    output rsp_valid, rsp_id, rsp_data, rsp_err
  );

endinterface

// File: rtl/mem_port_arbiter_pick.sv
// Fixed-priority grant (store > load > fetch) with a starvation counter that forces fetch
// to win once it has lost STARVE_MAX arbitrations in a row.
module mem_arb_pick
  import mem_arb_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [2:0] i_valid,    // {store, load, fetch}
  input  logic       i_in_idle,
  output logic [2:0] o_grant,    // one-hot, same order as i_valid
  output req_id_t    o_id
);

  localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);

  logic [CNT_W-1:0] r_starve_cnt;
  logic [CNT_W-1:0] w_starve_cnt_next;
  logic             w_force_fetch;

  always_comb begin
    w_force_fetch = (r_starve_cnt == CNT_W'(STARVE_MAX)) && i_valid[0];
    o_grant       = 3'b000;
    o_id          = REQ_FETCH;
    if (i_in_idle) begin
      if (w_force_fetch) begin
        o_grant = 3'b001;
        o_id    = REQ_FETCH;
      end else if (i_valid[2]) begin
        o_grant = 3'b100;
        o_id    = REQ_STORE;
      end else if (i_valid[1]) begin
        o_grant = 3'b010;
        o_id    = REQ_LOAD;
      end else if (i_valid[0]) begin
        o_grant = 3'b001;
        o_id    = REQ_FETCH;
      end
    end
  end

  always_comb begin
    w_starve_cnt_next = r_starve_cnt;
    if (i_in_idle) begin
      if (!i_valid[0] || o_grant[0]) begin
        w_starve_cnt_next = '0;
      end else if (r_starve_cnt != CNT_W'(STARVE_MAX)) begin
        w_starve_cnt_next = r_starve_cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_starve_cnt <= '0;
    end else begin
      r_starve_cnt <= w_starve_cnt_next;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises fetch/load/store onto one memory port, one transaction in flight, and returns
// each result on a single tagged response pulse.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned MEM_LAT    = 2,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  mem_port_arbiter_if.slave   io_bus
);

  localparam int unsigned LAT_W = $clog2(MEM_LAT + 1);

  arb_state_t        r_state;
  arb_state_t        w_state_next;
  req_id_t           r_id;
  req_id_t           w_pick_id;
  logic [2:0]        w_valid;
  logic [2:0]        w_grant;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] w_req_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;
  logic [LAT_W-1:0]  r_lat_cnt;
  logic              w_in_idle;
  logic              w_handshake;
  logic              w_err;
  logic              w_lat_done;

  assign w_valid     = {io_bus.store_valid, io_bus.load_valid, io_bus.fetch_valid};
  // Gating with reset keeps every ready low while reset is asserted.
  assign w_in_idle   = (r_state == IDLE) && i_rst_n;
  assign w_handshake = |w_grant;
  assign w_err       = is_misaligned(r_addr[1:0]);
  assign w_lat_done  = (r_lat_cnt == LAT_W'(MEM_LAT));

  mem_arb_pick #(
    .STARVE_MAX (STARVE_MAX)
  ) u_pick (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_valid   (w_valid),
    .i_in_idle (w_in_idle),
    .o_grant   (w_grant),
    .o_id      (w_pick_id)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_handshake) w_state_next = ACCESS;
      ACCESS:  w_state_next = (w_err || r_id == REQ_STORE) ? RESP : WAIT;
      WAIT:    if (w_lat_done) w_state_next = RESP;
      RESP:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    case (w_pick_id)
      REQ_STORE: w_req_addr = io_bus.store_addr;
      REQ_LOAD:  w_req_addr = io_bus.load_addr;
      default:   w_req_addr = io_bus.fetch_addr;
    endcase
  end

  // Request latch, latency counter and read-data capture.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_id      <= REQ_FETCH;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_rdata   <= '0;
      r_lat_cnt <= '0;
    end else begin
      if (w_handshake) begin
        r_id    <= w_pick_id;
        r_addr  <= w_req_addr;
        r_wdata <= w_grant[2] ? io_bus.store_data : '0;
      end
      if (r_state == ACCESS) begin
        r_lat_cnt <= LAT_W'(1);
      end else if (r_state == WAIT && !w_lat_done) begin
        r_lat_cnt <= r_lat_cnt + LAT_W'(1);
      end
      if (r_state == WAIT && w_lat_done) begin
        r_rdata <= io_bus.mem_rdata;
      end
    end
  end

  always_comb begin
    io_bus.fetch_ready = w_grant[0];
    io_bus.load_ready  = w_grant[1];
    io_bus.store_ready = w_grant[2];
    io_bus.mem_en      = 1'b0;
    io_bus.mem_we      = 1'b0;
    io_bus.mem_addr    = '0;
    io_bus.mem_wdata   = '0;
    io_bus.rsp_valid   = 1'b0;
    io_bus.rsp_id      = '0;
    io_bus.rsp_data    = '0;
    io_bus.rsp_err     = 1'b0;
    case (r_state)
      ACCESS: begin
        io_bus.mem_en    = !w_err;
        io_bus.mem_we    = !w_err && (r_id == REQ_STORE);
        io_bus.mem_addr  = r_addr;
        io_bus.mem_wdata = r_wdata;
      end
      RESP: begin
        io_bus.rsp_valid = 1'b1;
        io_bus.rsp_id    = r_id;
        io_bus.rsp_err   = w_err;
        io_bus.rsp_data  = (w_err || r_id == REQ_STORE) ? '0 : r_rdata;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a fixed-latency RAM model whose read data is
// only valid on the exact cycle MEM_LAT after the access strobe.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int unsigned ADDR_W     = 32;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned MEM_LAT    = 2;
  localparam int unsigned STARVE_MAX = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   total = 0;
  int   bad   = 0;

  mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_port_arbiter #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .MEM_LAT    (MEM_LAT),
    .STARVE_MAX (STARVE_MAX)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .io_bus  (bus)
  );

  always #5 clk = ~clk;

  logic        pipe_v [MEM_LAT];
  logic [31:0] pipe_a [MEM_LAT];

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return 32'hDEADBEEF + (a - 32'h100);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MEM_LAT; i++) begin
        pipe_v[i] <= 1'b0;
        pipe_a[i] <= '0;
      end
    end else begin
      pipe_v[0] <= bus.mem_en && !bus.mem_we;
      pipe_a[0] <= bus.mem_addr;
      for (int i = 1; i < MEM_LAT; i++) begin
        pipe_v[i] <= pipe_v[i-1];
        pipe_a[i] <= pipe_a[i-1];
      end
    end
  end

  assign bus.mem_rdata = pipe_v[MEM_LAT-1] ? mem_fn(pipe_a[MEM_LAT-1]) : 32'hBAD0BAD0;

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    bus.fetch_valid = 1'b1;
    bus.load_valid  = 1'b1;
    bus.store_valid = 1'b1;
    #1;
    total++;
    if ({bus.store_ready, bus.load_ready, bus.fetch_ready} !== 3'b000) begin
      bad++;
      $display("FAIL reset_ready: got %b want 000",
               {bus.store_ready, bus.load_ready, bus.fetch_ready});
    end
    total++;
    if ({bus.mem_en, bus.mem_we, bus.rsp_valid, bus.rsp_err} !== 4'b0000) begin
      bad++;
      $display("FAIL reset_ctrl: got %b want 0000",
               {bus.mem_en, bus.mem_we, bus.rsp_valid, bus.rsp_err});
    end
    total++;
    if ({bus.mem_addr, bus.mem_wdata, bus.rsp_data, bus.rsp_id} !== '0) begin
      bad++;
      $display("FAIL reset_bus: got %h %h %h %h want 0", bus.mem_addr, bus.mem_wdata,
               bus.rsp_data, bus.rsp_id);
    end
    total++;
    if (dut.u_pick.r_starve_cnt !== 3'd0) begin
      bad++;
      $display("FAIL reset_starve: got %0d want 0", dut.u_pick.r_starve_cnt);
    end
    bus.fetch_valid = 1'b0;
    bus.load_valid  = 1'b0;
    bus.store_valid = 1'b0;
    #1 rst_n = 1'b1;
  endtask

  task automatic test_load;
    next_cycle();
    bus.load_valid = 1'b1;
    bus.load_addr  = 32'h100;
    #1;
    total++;
    if ({bus.store_ready, bus.load_ready, bus.fetch_ready} !== 3'b010) begin
      bad++;
      $display("FAIL load_ready: got %b want 010",
               {bus.store_ready, bus.load_ready, bus.fetch_ready});
    end
    next_cycle();
    bus.load_valid = 1'b0;
    bus.load_addr  = 32'hFFFF_FFF0;
    #1;
    total++;
    if ({bus.mem_en, bus.mem_we, bus.rsp_valid} !== 3'b100 || bus.mem_addr !== 32'h100) begin
      bad++;
      $display("FAIL load_access: got en/we/rsp=%b addr=%h want 100 addr=00000100",
               {bus.mem_en, bus.mem_we, bus.rsp_valid}, bus.mem_addr);
    end
    for (int k = 2; k <= 5; k++) begin
      next_cycle();
      #1;
      total++;
      if (bus.rsp_valid !== (k == 4)) begin
        bad++;
        $display("FAIL load_rsp_valid T+%0d: got %b want %b", k, bus.rsp_valid, k == 4);
      end
      if (k == 4) begin
        total++;
        if (bus.rsp_id !== REQ_LOAD || bus.rsp_data !== 32'hDEADBEEF || bus.rsp_err !== 1'b0) begin
          bad++;
          $display("FAIL load_rsp: got id=%0d data=%h err=%b want id=1 data=deadbeef err=0",
                   bus.rsp_id, bus.rsp_data, bus.rsp_err);
        end
      end
    end
  endtask

  task automatic test_priority;
    logic [2:0] exp_rdy;
    next_cycle();
    bus.fetch_valid = 1'b1;
    bus.fetch_addr  = 32'h200;
    bus.load_valid  = 1'b1;
    bus.load_addr   = 32'h300;
    bus.store_valid = 1'b1;
    bus.store_addr  = 32'h400;
    bus.store_data  = 32'h55AA;
    for (int c = 0; c <= 13; c++) begin
      if (c > 0) next_cycle();
      if (c == 1) bus.store_valid = 1'b0;
      if (c == 4) bus.load_valid = 1'b0;
      if (c == 9) bus.fetch_valid = 1'b0;
      #1;
      exp_rdy = (c == 0) ? 3'b100 : (c == 3) ? 3'b010 : (c == 8) ? 3'b001 : 3'b000;
      total++;
      if ({bus.store_ready, bus.load_ready, bus.fetch_ready} !== exp_rdy) begin
        bad++;
        $display("FAIL prio_ready c=%0d: got %b want %b", c,
                 {bus.store_ready, bus.load_ready, bus.fetch_ready}, exp_rdy);
      end
      total++;
      if (bus.rsp_valid !== (c == 2 || c == 7 || c == 12)) begin
        bad++;
        $display("FAIL prio_rsp_valid c=%0d: got %b", c, bus.rsp_valid);
      end
      if (c == 2 || c == 7 || c == 12) begin
        total++;
        if ((c == 2  && (bus.rsp_id !== REQ_STORE || bus.rsp_data !== 32'h0)) ||
            (c == 7  && (bus.rsp_id !== REQ_LOAD  || bus.rsp_data !== mem_fn(32'h300))) ||
            (c == 12 && (bus.rsp_id !== REQ_FETCH || bus.rsp_data !== mem_fn(32'h200))) ||
            bus.rsp_err !== 1'b0) begin
          bad++;
          $display("FAIL prio_rsp c=%0d: got id=%0d data=%h err=%b", c, bus.rsp_id,
                   bus.rsp_data, bus.rsp_err);
        end
      end
    end
  endtask

  task automatic test_starve;
    logic [2:0] exp_rdy;
    req_id_t    exp_id;
    bit         found;
    for (int n = 1; n <= 5; n++) begin
      next_cycle();
      bus.fetch_valid = 1'b1;
      bus.fetch_addr  = 32'h500;
      if (n % 2 == 1) begin
        bus.store_valid = 1'b1;
        bus.store_addr  = 32'h80;
        bus.store_data  = 32'(n);
      end else begin
        bus.load_valid = 1'b1;
        bus.load_addr  = 32'h90;
      end
      #1;
      total++;
      if (dut.u_pick.r_starve_cnt !== 3'(n - 1)) begin
        bad++;
        $display("FAIL starve_cnt round %0d: got %0d want %0d", n, dut.u_pick.r_starve_cnt,
                 n - 1);
      end
      exp_rdy = (n == 5) ? 3'b001 : (n % 2 == 1) ? 3'b100 : 3'b010;
      exp_id  = (n == 5) ? REQ_FETCH : (n % 2 == 1) ? REQ_STORE : REQ_LOAD;
      total++;
      if ({bus.store_ready, bus.load_ready, bus.fetch_ready} !== exp_rdy) begin
        bad++;
        $display("FAIL starve_ready round %0d: got %b want %b", n,
                 {bus.store_ready, bus.load_ready, bus.fetch_ready}, exp_rdy);
      end
      next_cycle();
      bus.store_valid = 1'b0;
      bus.load_valid  = 1'b0;
      if (n == 5) begin
        bus.fetch_valid = 1'b0;
        #1;
        total++;
        if (dut.u_pick.r_starve_cnt !== 3'd0) begin
          bad++;
          $display("FAIL starve_clear: got %0d want 0", dut.u_pick.r_starve_cnt);
        end
      end
      found = 1'b0;
      for (int i = 0; i < 10 && !found; i++) begin
        next_cycle();
        #1;
        if (bus.rsp_valid === 1'b1) found = 1'b1;
      end
      total++;
      if (!found || bus.rsp_id !== exp_id) begin
        bad++;
        $display("FAIL starve_rsp round %0d: got found=%b id=%0d want id=%0d", n, found,
                 bus.rsp_id, exp_id);
      end
    end
  endtask

  task automatic test_misaligned;
    next_cycle();
    bus.load_valid = 1'b1;
    bus.load_addr  = 32'h102;
    #1;
    total++;
    if (bus.load_ready !== 1'b1) begin
      bad++;
      $display("FAIL misal_ready: got %b want 1", bus.load_ready);
    end
    next_cycle();
    bus.load_valid = 1'b0;
    #1;
    total++;
    if ({bus.mem_en, bus.mem_we, bus.rsp_valid} !== 3'b000) begin
      bad++;
      $display("FAIL misal_access: got en/we/rsp=%b want 000",
               {bus.mem_en, bus.mem_we, bus.rsp_valid});
    end
    next_cycle();
    #1;
    total++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== REQ_LOAD || bus.rsp_err !== 1'b1 ||
        bus.rsp_data !== 32'h0 || bus.mem_en !== 1'b0) begin
      bad++;
      $display("FAIL misal_rsp: got v=%b id=%0d err=%b data=%h en=%b want v=1 id=1 err=1 data=0",
               bus.rsp_valid, bus.rsp_id, bus.rsp_err, bus.rsp_data, bus.mem_en);
    end
  endtask

  task automatic test_store;
    next_cycle();
    bus.store_valid = 1'b1;
    bus.store_addr  = 32'h40;
    bus.store_data  = 32'h1234;
    #1;
    total++;
    if ({bus.store_ready, bus.load_ready, bus.fetch_ready} !== 3'b100) begin
      bad++;
      $display("FAIL store_ready: got %b want 100",
               {bus.store_ready, bus.load_ready, bus.fetch_ready});
    end
    next_cycle();
    bus.store_valid = 1'b0;
    bus.store_data  = 32'hFFFF;
    #1;
    total++;
    if ({bus.mem_en, bus.mem_we} !== 2'b11 || bus.mem_addr !== 32'h40 ||
        bus.mem_wdata !== 32'h1234) begin
      bad++;
      $display("FAIL store_access: got en/we=%b addr=%h wdata=%h want 11 40 1234",
               {bus.mem_en, bus.mem_we}, bus.mem_addr, bus.mem_wdata);
    end
    next_cycle();
    #1;
    total++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== REQ_STORE || bus.rsp_data !== 32'h0 ||
        bus.rsp_err !== 1'b0) begin
      bad++;
      $display("FAIL store_rsp: got v=%b id=%0d data=%h err=%b want v=1 id=2 data=0 err=0",
               bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.rsp_err);
    end
  endtask

  task automatic test_reset_mid;
    next_cycle();
    bus.load_valid = 1'b1;
    bus.load_addr  = 32'h600;
    next_cycle();
    bus.load_valid = 1'b0;
    next_cycle();
    rst_n           = 1'b0;
    bus.fetch_valid = 1'b1;
    bus.fetch_addr  = 32'h700;
    #1;
    total++;
    if ({bus.store_ready, bus.load_ready, bus.fetch_ready, bus.mem_en, bus.mem_we,
         bus.rsp_valid, bus.rsp_err} !== 7'b0 || bus.mem_addr !== '0 || bus.rsp_data !== '0) begin
      bad++;
      $display("FAIL midreset_outputs: got ctrl=%b addr=%h data=%h want 0",
               {bus.store_ready, bus.load_ready, bus.fetch_ready, bus.mem_en, bus.mem_we,
                bus.rsp_valid, bus.rsp_err}, bus.mem_addr, bus.rsp_data);
    end
    next_cycle();
    bus.fetch_valid = 1'b0;
    #1 rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      next_cycle();
      #1;
      total++;
      if (bus.rsp_valid !== 1'b0) begin
        bad++;
        $display("FAIL midreset_no_rsp cycle %0d: got %b want 0", k, bus.rsp_valid);
      end
    end
    next_cycle();
    bus.fetch_valid = 1'b1;
    #1;
    total++;
    if (bus.fetch_ready !== 1'b1) begin
      bad++;
      $display("FAIL midreset_fetch_ready: got %b want 1", bus.fetch_ready);
    end
    next_cycle();
    bus.fetch_valid = 1'b0;
    for (int k = 2; k <= 4; k++) begin
      next_cycle();
      #1;
      total++;
      if (bus.rsp_valid !== (k == 4)) begin
        bad++;
        $display("FAIL midreset_rsp_valid T+%0d: got %b", k, bus.rsp_valid);
      end
    end
    total++;
    if (bus.rsp_id !== REQ_FETCH || bus.rsp_data !== mem_fn(32'h700) || bus.rsp_err !== 1'b0) begin
      bad++;
      $display("FAIL midreset_rsp: got id=%0d data=%h err=%b want id=0 data=%h err=0",
               bus.rsp_id, bus.rsp_data, bus.rsp_err, mem_fn(32'h700));
    end
  endtask

  initial begin
    bus.fetch_valid = 1'b0;
    bus.fetch_addr  = '0;
    bus.load_valid  = 1'b0;
    bus.load_addr   = '0;
    bus.store_valid = 1'b0;
    bus.store_addr  = '0;
    bus.store_data  = '0;
    test_reset();
    test_load();
    test_priority();
    test_starve();
    test_misaligned();
    test_store();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1);
  end

endmodule
